cache_mem_responder: RTL and testbench



---
 rtl/cache_mem_pkg.sv | 32 +++
 rtl/cache_mem_responder_if.sv | 28 ++
 rtl/resp_ram.sv | 37 +++
 rtl/cache_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_cache_mem_responder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types for the cache memory responder: request type codes, FSM states,
// and the line-lane extraction helper.
package cache_mem_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam int LINE_WORDS = 4;
  localparam int BEAT_W     = 2;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    RD_WAIT  = 4'b0010,
    RD_BURST = 4'b0100,
    WR_DRAIN = 4'b1000
  } state_t;

  function automatic logic [31:0] lane_word(input logic [127:0] line, input logic [1:0] lane);
    case (lane)
      2'd0:    return line[31:0];
      2'd1:    return line[63:32];
      2'd2:    return line[95:64];
      2'd3:    return line[127:96];
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/cache_mem_responder_if.sv
// Cache-to-memory bus: read request, read return and write channels.
interface cache_mem_responder_if;

  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;

  modport master (
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );

  modport slave (
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );

endinterface

// File: rtl/resp_ram.sv
// Single-port synchronous word RAM with byte write enables and a read register
// that only updates on a read, so its output holds the last word fetched.
module resp_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [0:(1<<AW)-1];

  // Byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register feeds ret_data directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 32'h0000_0000;
    end else if (re) begin
      rdata <= mem_r[addr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: one read or write at a time, line reads returned as
// four gapless beats, writes drained from a one-entry buffer before going idle.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int MEM_AW = 12,
  parameter int RD_LAT = 3
) (
  input logic                  clk,
  input logic                  reset,
  cache_mem_responder_if.slave bus
);

  localparam int LAT_W = (RD_LAT > 3) ? $clog2(RD_LAT) : 2;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 2);

  state_t              state_r;
  logic [LAT_W-1:0]    lat_r;
  beat_t               beat_r;
  logic [MEM_AW-1:0]   rd_word_r;
  logic                rd_line_r;
  logic [MEM_AW-1:0]   wr_word_r;
  logic                wr_line_r;
  logic [3:0]          wr_strb_r;
  logic [127:0]        wr_buf_r;
  logic                buf_valid_r;
  logic                ret_valid_r;
  logic                ret_last_r;

  logic                issue_s;
  beat_t               beat_nxt_s;
  logic [3:0]          ram_we_s;
  logic [MEM_AW-1:0]   ram_addr_s;
  logic [31:0]         ram_wdata_s;
  logic [31:0]         ram_rdata_s;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{bus.rd_addr[31:MEM_AW+2], bus.rd_addr[1:0],
                              bus.wr_addr[31:MEM_AW+2], bus.wr_addr[1:0]};

  assign beat_nxt_s = beat_r + 2'd1;

  // RAM port mux: read issue one cycle ahead of each beat, or buffer drain.
  always_comb begin
    issue_s     = 1'b0;
    ram_we_s    = 4'b0000;
    ram_addr_s  = '0;
    ram_wdata_s = 32'h0000_0000;
    case (state_r)
      RD_WAIT: begin
        if (lat_r == LAT_LAST) begin
          issue_s    = 1'b1;
          ram_addr_s = rd_line_r ? {rd_word_r[MEM_AW-1:2], 2'b00} : rd_word_r;
        end else begin
          issue_s    = 1'b0;
        end
      end
      RD_BURST: begin
        if (!ret_last_r) begin
          issue_s    = 1'b1;
          ram_addr_s = {rd_word_r[MEM_AW-1:2], beat_nxt_s};
        end else begin
          issue_s    = 1'b0;
        end
      end
      WR_DRAIN: begin
        if (buf_valid_r && !reset) begin
          if (wr_line_r) begin
            ram_we_s    = 4'b1111;
            ram_addr_s  = {wr_word_r[MEM_AW-1:2], beat_r};
            ram_wdata_s = lane_word(wr_buf_r, beat_r);
          end else begin
            ram_we_s    = wr_strb_r;
            ram_addr_s  = wr_word_r;
            ram_wdata_s = lane_word(wr_buf_r, wr_word_r[1:0]);
          end
        end else begin
          ram_we_s = 4'b0000;
        end
      end
      default: begin
        issue_s = 1'b0;
      end
    endcase
  end

  // Control FSM with registered return strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      lat_r       <= '0;
      beat_r      <= '0;
      buf_valid_r <= 1'b0;
      ret_valid_r <= 1'b0;
      ret_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ret_valid_r <= 1'b0;
          ret_last_r  <= 1'b0;
          if (bus.wr_req) begin
            wr_word_r   <= bus.wr_addr[MEM_AW+1:2];
            wr_line_r   <= (bus.wr_type == TYPE_LINE);
            wr_strb_r   <= bus.wr_wstrb;
            wr_buf_r    <= bus.wr_data;
            buf_valid_r <= 1'b1;
            beat_r      <= '0;
            state_r     <= WR_DRAIN;
          end else if (bus.rd_req) begin
            rd_word_r <= bus.rd_addr[MEM_AW+1:2];
            rd_line_r <= (bus.rd_type == TYPE_LINE);
            lat_r     <= '0;
            state_r   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (issue_s) begin
            beat_r      <= '0;
            ret_valid_r <= 1'b1;
            ret_last_r  <= !rd_line_r;
            state_r     <= RD_BURST;
          end else begin
            lat_r <= lat_r + 1'b1;
          end
        end
        RD_BURST: begin
          if (ret_last_r) begin
            ret_valid_r <= 1'b0;
            ret_last_r  <= 1'b0;
            state_r     <= IDLE;
          end else begin
            beat_r      <= beat_nxt_s;
            ret_valid_r <= 1'b1;
            ret_last_r  <= (beat_r == 2'd2);
          end
        end
        WR_DRAIN: begin
          if (!buf_valid_r || !wr_line_r || (beat_r == 2'd3)) begin
            buf_valid_r <= 1'b0;
            beat_r      <= '0;
            state_r     <= IDLE;
          end else begin
            beat_r <= beat_nxt_s;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  resp_ram #(.AW(MEM_AW)) u_ram (
    .clk   (clk),
    .reset (reset),
    .re    (issue_s),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  assign bus.wr_rdy    = (state_r == IDLE) && !reset;
  assign bus.rd_rdy    = (state_r == IDLE) && !reset && !bus.wr_req;
  assign bus.ret_valid = ret_valid_r;
  assign bus.ret_last  = ret_last_r;
  assign bus.ret_data  = ram_rdata_s;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: reads push expected beats with due
// cycles at accept time, an independent monitor pops and compares each beat.
module tb_cache_mem_responder;
  import cache_mem_pkg::*;

  localparam int RD_LAT = 3;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          due;
  } exp_beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_beat_t sb[$];

  cache_mem_responder_if bus();

  cache_mem_responder #(.MEM_AW(12), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every visible beat must match the head of the scoreboard.
  initial forever begin
    exp_beat_t e;
    @(negedge clk);
    if (!reset) begin
      check("last_without_valid", bus.ret_last && !bus.ret_valid, 1'b0);
      if (bus.ret_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check("ret_data", bus.ret_data, e.data);
          check("ret_last", bus.ret_last, e.last);
          check("beat_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic do_write(input logic [2:0] typ, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [127:0] data, input int exp_busy);
    int busy;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.wr_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("wr_rdy_timeout", 1'b0, 1'b1);
    end
    bus.wr_req   = 1'b1;
    bus.wr_type  = typ;
    bus.wr_addr  = addr;
    bus.wr_wstrb = strb;
    bus.wr_data  = data;
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.wr_rdy) break;
      busy++;
    end
    check("wr_busy_cycles", busy, exp_busy);
    @(posedge clk); #1;
  endtask

  // Push nb expected beats (lane words of line) once the accept cycle is known.
  task automatic do_read(input logic [2:0] typ, input logic [31:0] addr, input logic [127:0] line,
                         input int nb, input bit hold, output int acc);
    exp_beat_t e;
    logic [127:0] l;
    bus.rd_type = typ;
    bus.rd_addr = addr;
    bus.rd_req  = 1'b1;
    acc = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.rd_rdy) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      check("rd_accept_timeout", 1'b0, 1'b1);
      bus.rd_req = 1'b0;
    end else begin
      l = line;
      for (int i = 0; i < nb; i++) begin
        e.data = l[32*i +: 32];
        e.last = (typ != TYPE_LINE) || (i == 3);
        e.due  = acc + RD_LAT + i;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      if (!hold) bus.rd_req = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.wr_rdy) break;
    end
    check("drained", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_A2 = 128'h44444444_1111CCDD_22222222_11111111;
  localparam logic [127:0] LINE_B = 128'h88888888_77777777_66666666_55555555;
  localparam logic [127:0] LINE_C = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

  initial begin
    int acc1, acc2, wacc;
    bit seen;
    bus.rd_req = 1'b0; bus.rd_type = 3'b000; bus.rd_addr = 32'h0;
    bus.wr_req = 1'b0; bus.wr_type = 3'b000; bus.wr_addr = 32'h0;
    bus.wr_wstrb = 4'h0; bus.wr_data = 128'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_rdy", bus.rd_rdy, 1'b0);
    check("rst_wr_rdy", bus.wr_rdy, 1'b0);
    check("rst_ret_valid", bus.ret_valid, 1'b0);
    check("rst_ret_last", bus.ret_last, 1'b0);
    check("rst_ret_data", bus.ret_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_wr_rdy", bus.wr_rdy, 1'b1);
    check("idle_rd_rdy", bus.rd_rdy, 1'b1);
    @(posedge clk); #1;

    // Line write then line read
    do_write(TYPE_LINE, 32'h1000, 4'h0, LINE_A, 4);
    do_read(TYPE_LINE, 32'h1000, LINE_A, 4, 1'b0, acc1);
    drain();

    // Uncached strobed write over an old word
    do_write(TYPE_WORD, 32'h1008, 4'b1111, {32'h0, 32'h11111111, 64'h0}, 1);
    do_write(TYPE_WORD, 32'h1008, 4'b0011, {32'h0, 32'hAABBCCDD, 64'h0}, 1);
    do_read(TYPE_WORD, 32'h1008, {96'h0, 32'h1111CCDD}, 1, 1'b0, acc1);
    do_read(TYPE_BYTE, 32'h1009, {96'h0, 32'h1111CCDD}, 1, 1'b0, acc1);
    drain();

    // Simultaneous read and write: write wins, read follows the drain
    bus.wr_req = 1'b1; bus.wr_type = TYPE_LINE; bus.wr_addr = 32'h2000;
    bus.wr_wstrb = 4'h0; bus.wr_data = LINE_B;
    bus.rd_req = 1'b1; bus.rd_type = TYPE_LINE; bus.rd_addr = 32'h2000;
    @(negedge clk);
    check("simul_rd_rdy", bus.rd_rdy, 1'b0);
    check("simul_wr_rdy", bus.wr_rdy, 1'b1);
    wacc = cyc;
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    do_read(TYPE_LINE, 32'h2000, LINE_B, 4, 1'b0, acc1);
    check("simul_rd_accept_gap", acc1 - wacc, 5);
    drain();

    // Back-to-back held line reads
    do_read(TYPE_LINE, 32'h1000, LINE_A2, 4, 1'b1, acc1);
    do_read(TYPE_LINE, 32'h2000, LINE_B, 4, 1'b0, acc2);
    check("b2b_accept_gap", acc2 - acc1, RD_LAT + 4);
    drain();

    // Reset during the second beat of a burst
    do_read(TYPE_LINE, 32'h1000, LINE_A2, 2, 1'b0, acc1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ret_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("burst_started", seen, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ret_valid", bus.ret_valid, 1'b0);
    check("midrst_ret_last", bus.ret_last, 1'b0);
    check("midrst_ret_data", bus.ret_data, 32'h0);
    check("midrst_rd_rdy", bus.rd_rdy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("postrst_idle", bus.wr_rdy, 1'b1);
    check("postrst_ret_valid", bus.ret_valid, 1'b0);
    @(posedge clk); #1;
    check("postrst_sb_empty", sb.size(), 0);
    do_read(TYPE_LINE, 32'h1000, LINE_A2, 4, 1'b0, acc1);
    drain();

    // Address aliasing above the RAM depth
    do_write(TYPE_LINE, 32'h0000, 4'h0, LINE_C, 4);
    do_read(TYPE_LINE, 32'h4000, LINE_C, 4, 1'b0, acc1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
